// File: rtl/unidade_controle_pkg.sv
// State encoding shared by the memory-game control unit and the benches that
// decode db_estado.
package unidade_controle_pkg;

    localparam int ESTADO_W = 5;

    localparam logic [4:0] INICIAL           = 5'h00;
    localparam logic [4:0] PREPARACAO        = 5'h01;
    localparam logic [4:0] ESPERA_JOGADA     = 5'h02;
    localparam logic [4:0] REGISTRA          = 5'h03;
    localparam logic [4:0] COMPARACAO        = 5'h04;
    localparam logic [4:0] PROXIMO_ENDERECO  = 5'h05;
    localparam logic [4:0] PROXIMA_SEQUENCIA = 5'h06;
    localparam logic [4:0] FIM_ACERTOU       = 5'h0A;
    localparam logic [4:0] FIM_ERROU         = 5'h0E;
    localparam logic [4:0] FIM_TIMEOUT       = 5'h0F;

endpackage

// File: rtl/unidade_controle.sv
// Moore control FSM for the memory game: sequences the fluxo_dados counters and
// move register, and judges one player move per visit to comparacao.
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int STATE_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               jogada_feita,
    input  logic               chavesIgualMemoria,
    input  logic               enderecoIgualLimite,
    input  logic               fimL,
    input  logic               timeout,
    output logic               zeraE,
    output logic               contaE,
    output logic               zeraL,
    output logic               contaL,
    output logic               zeraR,
    output logic               registraR,
    output logic               pronto,
    output logic               ganhou,
    output logic               perdeu,
    output logic               db_timeout,
    output logic [STATE_W-1:0] db_estado
);

    logic [ESTADO_W-1:0] estadoAtual;
    logic [ESTADO_W-1:0] proximoEstado;

    always_ff @(posedge clock) begin
        if (reset) begin
            estadoAtual <= INICIAL;
        end else begin
            estadoAtual <= proximoEstado;
        end
    end

    // Timeout is tested before jogada_feita so a late press cannot rescue an expired move.
    always_comb begin
        proximoEstado = INICIAL;
        case (estadoAtual)
            INICIAL:           proximoEstado = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:        proximoEstado = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (timeout)           proximoEstado = FIM_TIMEOUT;
                else if (jogada_feita) proximoEstado = REGISTRA;
                else                   proximoEstado = ESPERA_JOGADA;
            end
            REGISTRA:          proximoEstado = COMPARACAO;
            COMPARACAO: begin
                if (!chavesIgualMemoria)       proximoEstado = FIM_ERROU;
                else if (!enderecoIgualLimite) proximoEstado = PROXIMO_ENDERECO;
                else if (fimL)                 proximoEstado = FIM_ACERTOU;
                else                           proximoEstado = PROXIMA_SEQUENCIA;
            end
            PROXIMO_ENDERECO:  proximoEstado = ESPERA_JOGADA;
            PROXIMA_SEQUENCIA: proximoEstado = ESPERA_JOGADA;
            FIM_ACERTOU:       proximoEstado = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:         proximoEstado = iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT:       proximoEstado = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:           proximoEstado = INICIAL;
        endcase
    end

    always_comb begin
        zeraE      = 1'b0;
        contaE     = 1'b0;
        zeraL      = 1'b0;
        contaL     = 1'b0;
        zeraR      = 1'b0;
        registraR  = 1'b0;
        pronto     = 1'b0;
        ganhou     = 1'b0;
        perdeu     = 1'b0;
        db_timeout = 1'b0;
        case (estadoAtual)
            PREPARACAO: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA:         registraR = 1'b1;
            PROXIMO_ENDERECO: contaE = 1'b1;
            PROXIMA_SEQUENCIA: begin
                contaL = 1'b1;
                zeraE  = 1'b1;
            end
            FIM_ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = STATE_W'(estadoAtual);

endmodule
